msg_scheduler: RTL and testbench
================================

Name: msg_scheduler

Overview:
- Round-robin scheduler that shares one downstream message path between N_CH input-process channels (SPI/UART deserializer + input FIFO blocks).
- Monitors each channel's GOT_FULL_MSG, grants one channel and pulses its MSG_START to latch the length.
- Emits a 16-bit header word, then drains exactly that many FIFO words through a 2-entry skid buffer to a valid/ready output.
- Sits between the input process blocks and the packet/tx formatter, all on SYS_CLK.

Parameters:
- N_CH, 2, number of input channels (1..16)
- HDR_MARK, 4'hA, constant in header bits [15:12]
- CH_W, $clog2(N_CH) min 1, channel index width

Ports:
- SYS_CLK  in  1  system clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- GOT_FULL_MSG  in  N_CH  per-channel "message ready" flag
- MSG_LEN  in  8*N_CH  per-channel length; channel i at [8i+7:8i]; valid the cycle after MSG_START
- FIFO_Q  in  16*N_CH  per-channel FIFO read data; channel i at [16i+15:16i]; valid 1 cycle after RD_REQ
- MSG_START  out  N_CH  one-hot, 1-cycle pulse to the granted channel
- RD_REQ  out  N_CH  one-hot FIFO read strobe to the granted channel
- OUT_DATA  out  16  header or payload word
- OUT_VALID  out  1  OUT_DATA valid
- OUT_READY  in  1  downstream accepts when VALID&READY
- OUT_SOP  out  1  high with header word
- OUT_EOP  out  1  high with last word (header if length 0)
- BUSY  out  1  high in every state except IDLE
- CUR_CH  out  CH_W  granted channel index, held until next grant

Behaviour:
- Reset (RST=1, async): state=IDLE; all outputs 0; rr pointer = N_CH-1 (first search starts at ch0); skid buffer empty; counters 0.
- IDLE: if any GOT_FULL_MSG set, grant the first set channel searching from ptr+1 modulo N_CH; load CUR_CH; go START. No request -> stay.
- START: assert MSG_START[CUR_CH] for exactly 1 cycle; go LEN.
- LEN: latch len=MSG_LEN[CUR_CH]; rem=len; go HDR.
- HDR: push header {HDR_MARK, 4'(CUR_CH), len} into the skid buffer with SOP=1, EOP=(len==0). Next: DATA if len>0, else DONE.
- DATA:
  - Assert RD_REQ[CUR_CH] in a cycle iff rem>0 and (buffered + in-flight) < 2.
  - Each RD_REQ decrements rem.
  - Word captured from FIFO_Q[CUR_CH] the next cycle; EOP set on the word whose read made rem 0.
  - Go DONE in the cycle after the last RD_REQ.
- DONE: wait until skid buffer empty and no read in flight; ptr=CUR_CH; go IDLE. Min gap between messages: 1 idle cycle.
- Skid buffer:
  - 2 entries, FIFO order; head drives OUT_DATA/SOP/EOP/VALID.
  - Pop on VALID&READY; simultaneous push and pop allowed.
  - Never overflows: the read credit rule guarantees this.
  - OUT_DATA/SOP/EOP stable while VALID & !READY.
- Throughput: 1 word/cycle with OUT_READY held high. Latency from GOT_FULL_MSG to header VALID is 4 cycles (IDLE, START, LEN, HDR -> registered out).
- GOT_FULL_MSG of non-granted channels is ignored until DONE->IDLE. A flag deasserting after grant does not abort the message.
- Length is used exactly as latched. Words arriving in the channel FIFO after the MSG_START sample go to the next message.
- RD_REQ and MSG_START are never high for a non-granted channel and never in the same cycle.
- RST mid-message: immediate return to reset values; partial message is dropped, no EOP is generated. Channel state is recovered by the channels' own reset.
- Length counter is 8 bits; maximum payload 254 by channel contract. 255 is handled correctly if received.

Decomposition:
- Shared package/defines: state encoding (IDLE, START, LEN, HDR, DATA, DONE), HDR_MARK, header field positions.
- Sub-module msg_skid_buf: 2-entry 18-bit (data+SOP+EOP) valid/ready buffer exposing a count output for the credit check.
- Round-robin pick is a function inside msg_scheduler.

Test Plan:
- Single channel, ch0 len=3, READY=1 -> MSG_START[0] 1 pulse; out A003, d0, d1, d2; SOP on A003, EOP on d2; 4 consecutive VALID cycles; RD_REQ[0] exactly 3 cycles.
- ch0 and ch1 both GOT_FULL_MSG after reset, len 2 each -> ch0 first (A002…), then ch1 (A102…); next simultaneous request goes to ch0 again (rr).
- len=0 on ch1 -> single word A100 with SOP=EOP=1; no RD_REQ.
- Backpressure, len=5, READY toggled 1,0,0,1,… -> no loss or duplication; never more than 2 outstanding reads; data held stable while stalled.
- len=254, READY=1 -> 255 output words, RD_REQ count 254, BUSY falls 1 cycle after final pop.
- RST pulsed during DATA with rem=10 -> all outputs 0 asynchronously; after release, new request starts cleanly from ch0.

Source files
------------

// File: rtl/msg_scheduler_pkg.sv
// Shared types for the message scheduler.
// State encoding, header layout and skid-buffer word format.
package msg_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LEN,
    S_HDR,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [3:0] HDR_MARK_DEF = 4'hA;

  localparam int HDR_MARK_LSB = 12;
  localparam int HDR_CH_LSB   = 8;
  localparam int HDR_LEN_LSB  = 0;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [15:0] data;
  } skid_word_t;

  function automatic logic [15:0] make_hdr(
    input logic [3:0] mark,
    input logic [3:0] ch,
    input logic [7:0] len
  );
    logic [15:0] h;
    h = '0;
    h[HDR_MARK_LSB +: 4] = mark;
    h[HDR_CH_LSB +: 4]   = ch;
    h[HDR_LEN_LSB +: 8]  = len;
    return h;
  endfunction

endpackage

// File: rtl/msg_scheduler_skid_buf.sv
// Two-entry FIFO-ordered valid/ready buffer.
// Head drives the output; count feeds the read-credit check.
module msg_skid_buf
  import msg_scheduler_pkg::*;
(
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic       push,
  input  skid_word_t push_word,
  input  logic       out_ready,
  output skid_word_t out_word,
  output logic       out_valid,
  output logic [1:0] count
);

  skid_word_t slot0;
  skid_word_t slot1;
  logic       pop;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_word  = slot0;

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_word;
          else               slot1 <= push_word;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= push_word;
          end else begin
            slot0 <= slot1;
            slot1 <= push_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/msg_scheduler.sv
// Round-robin message scheduler: header word then payload
// drained from the granted channel FIFO through a skid buffer.
module msg_scheduler
  import msg_scheduler_pkg::*;
#(
  parameter int         N_CH     = 2,
  parameter logic [3:0] HDR_MARK = HDR_MARK_DEF,
  parameter int         CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 SYS_CLK,
  input  logic                 RST,
  input  logic [N_CH-1:0]      GOT_FULL_MSG,
  input  logic [8*N_CH-1:0]    MSG_LEN,
  input  logic [16*N_CH-1:0]   FIFO_Q,
  output logic [N_CH-1:0]      MSG_START,
  output logic [N_CH-1:0]      RD_REQ,
  output logic [15:0]          OUT_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 OUT_SOP,
  output logic                 OUT_EOP,
  output logic                 BUSY,
  output logic [CH_W-1:0]      CUR_CH
);

  state_t          state;
  state_t          state_nx;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] cur_ch;
  logic [7:0]      len;
  logic [7:0]      rem;
  logic            rd_fly;
  logic            rd_fly_eop;
  logic            rd;
  logic            last_rd;
  logic            hdr_push;
  logic            push;
  logic            pop;
  skid_word_t      push_word;
  skid_word_t      head;
  logic [1:0]      sb_cnt;
  logic [2:0]      in_use;
  logic [N_CH-1:0] ch_hot;
  logic [7:0]      len_sel;
  logic [15:0]     q_sel;

  function automatic logic [CH_W-1:0] rr_pick(
    input logic [N_CH-1:0] req,
    input logic [CH_W-1:0] p
  );
    logic [CH_W-1:0] pick;
    int              idx;
    pick = p;
    // Walk offsets far-to-near so the nearest hit wins.
    for (int k = N_CH; k >= 1; k--) begin
      idx = (int'(p) + k) % N_CH;
      if (req[idx]) pick = CH_W'(idx);
    end
    return pick;
  endfunction

  assign ch_hot  = N_CH'(1) << cur_ch;
  assign len_sel = MSG_LEN[8*cur_ch +: 8];
  assign q_sel   = FIFO_Q[16*cur_ch +: 16];

  assign hdr_push = (state == S_HDR);
  assign push     = hdr_push | rd_fly;
  assign pop      = OUT_VALID & OUT_READY;

  always_comb begin
    push_word = '0;
    if (hdr_push) begin
      push_word.sop  = 1'b1;
      push_word.eop  = (len == 8'd0);
      push_word.data = make_hdr(HDR_MARK, 4'(cur_ch), len);
    end else begin
      push_word.eop  = rd_fly_eop;
      push_word.data = q_sel;
    end
  end

  // Occupancy after this cycle's push/pop; a new read needs a free slot.
  assign in_use = 3'(sb_cnt) + 3'(push) - 3'(pop);

  msg_skid_buf u_skid (
    .SYS_CLK   (SYS_CLK),
    .RST       (RST),
    .push      (push),
    .push_word (push_word),
    .out_ready (OUT_READY),
    .out_word  (head),
    .out_valid (OUT_VALID),
    .count     (sb_cnt)
  );

  assign OUT_DATA = head.data;
  assign OUT_SOP  = head.sop & OUT_VALID;
  assign OUT_EOP  = head.eop & OUT_VALID;
  assign CUR_CH   = cur_ch;

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (|GOT_FULL_MSG) state_nx = S_START;
      S_START: state_nx = S_LEN;
      S_LEN:   state_nx = S_HDR;
      S_HDR: begin
        if (len == 8'd0 || last_rd) state_nx = S_DONE;
        else                        state_nx = S_DATA;
      end
      S_DATA:  if (last_rd) state_nx = S_DONE;
      S_DONE:  if (in_use == 3'd0) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    MSG_START = '0;
    RD_REQ    = '0;
    rd        = 1'b0;
    BUSY      = (state != S_IDLE);
    unique case (state)
      S_START: MSG_START = ch_hot;
      S_HDR, S_DATA: begin
        rd     = (rem != 8'd0) && (in_use < 3'd2);
        RD_REQ = rd ? ch_hot : '0;
      end
      default: ;
    endcase
  end

  assign last_rd = rd && (rem == 8'd1);

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      ptr        <= CH_W'(N_CH - 1);
      cur_ch     <= '0;
      len        <= '0;
      rem        <= '0;
      rd_fly     <= 1'b0;
      rd_fly_eop <= 1'b0;
    end else begin
      rd_fly     <= rd;
      rd_fly_eop <= last_rd;
      if (state == S_IDLE && |GOT_FULL_MSG)
        cur_ch <= rr_pick(GOT_FULL_MSG, ptr);
      if (state == S_LEN) begin
        len <= len_sel;
        rem <= len_sel;
      end else if (rd) begin
        rem <= rem - 8'd1;
      end
      if (state == S_DONE && state_nx == S_IDLE)
        ptr <= cur_ch;
    end
  end

endmodule

// File: tb/tb_msg_scheduler.sv
// Directed bench for msg_scheduler with a 2-channel FIFO model.
// Expected words are hand-computed per scenario.
module tb_msg_scheduler;

  logic        SYS_CLK = 1'b0;
  logic        RST;
  logic [1:0]  GOT_FULL_MSG;
  logic [15:0] MSG_LEN;
  logic [31:0] FIFO_Q = '0;
  logic [1:0]  MSG_START;
  logic [1:0]  RD_REQ;
  logic [15:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        OUT_SOP;
  logic        OUT_EOP;
  logic        BUSY;
  logic [0:0]  CUR_CH;

  msg_scheduler #(.N_CH(2)) dut (
    .SYS_CLK      (SYS_CLK),
    .RST          (RST),
    .GOT_FULL_MSG (GOT_FULL_MSG),
    .MSG_LEN      (MSG_LEN),
    .FIFO_Q       (FIFO_Q),
    .MSG_START    (MSG_START),
    .RD_REQ       (RD_REQ),
    .OUT_DATA     (OUT_DATA),
    .OUT_VALID    (OUT_VALID),
    .OUT_READY    (OUT_READY),
    .OUT_SOP      (OUT_SOP),
    .OUT_EOP      (OUT_EOP),
    .BUSY         (BUSY),
    .CUR_CH       (CUR_CH)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  // Channel FIFO model: ch0 words 0x0100+k, ch1 0x0200+k.
  int src_cnt [2];
  always @(posedge SYS_CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (MSG_START[i]) begin
        src_cnt[i] <= 0;
      end else if (RD_REQ[i]) begin
        FIFO_Q[16*i +: 16] <= 16'(256 * (i + 1) + src_cnt[i]);
        src_cnt[i] <= src_cnt[i] + 1;
      end
    end
  end

  logic        mon_clr = 1'b0;
  logic [17:0] mon_word;
  logic [17:0] got_q [$];
  logic [17:0] prev_word;
  logic        prev_valid;
  logic        prev_ready;
  logic        busy_q;
  int rd_cnt [2];
  int ms_cnt [2];
  int cyc, cur_run, max_run, stall_err, stall_n, excl_err;
  int rd_tot, dpop_tot, max_out;
  int last_pop_cyc, busy_fall_cyc, gfm_cyc, hdr_cyc;

  assign mon_word = {OUT_SOP, OUT_EOP, OUT_DATA};

  always @(negedge SYS_CLK) begin
    if (mon_clr) begin
      got_q.delete();
      rd_cnt <= '{0, 0};
      ms_cnt <= '{0, 0};
      cyc <= 0; cur_run <= 0; max_run <= 0;
      stall_err <= 0; stall_n <= 0; excl_err <= 0;
      rd_tot <= 0; dpop_tot <= 0; max_out <= 0;
      last_pop_cyc <= -1; busy_fall_cyc <= -1;
      gfm_cyc <= -1; hdr_cyc <= -1;
      prev_valid <= 1'b0; prev_ready <= 1'b0;
      prev_word <= '0; busy_q <= BUSY;
    end else if (!RST) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        rd_cnt[i] <= rd_cnt[i] + int'(RD_REQ[i]);
        ms_cnt[i] <= ms_cnt[i] + int'(MSG_START[i]);
      end
      if (OUT_VALID && OUT_READY) begin
        got_q.push_back(mon_word);
        last_pop_cyc <= cyc;
      end
      cur_run <= OUT_VALID ? cur_run + 1 : 0;
      if (OUT_VALID && cur_run + 1 > max_run) max_run <= cur_run + 1;
      if (prev_valid && !prev_ready) begin
        stall_n <= stall_n + 1;
        if (!OUT_VALID || mon_word !== prev_word)
          stall_err <= stall_err + 1;
      end
      prev_valid <= OUT_VALID;
      prev_ready <= OUT_READY;
      prev_word  <= mon_word;
      rd_tot   <= rd_tot + int'(RD_REQ != 0);
      dpop_tot <= dpop_tot + int'(OUT_VALID && OUT_READY && !OUT_SOP);
      if (rd_tot + int'(RD_REQ != 0) - dpop_tot
          - int'(OUT_VALID && OUT_READY && !OUT_SOP) > max_out)
        max_out <= rd_tot + int'(RD_REQ != 0) - dpop_tot
                   - int'(OUT_VALID && OUT_READY && !OUT_SOP);
      if (busy_q && !BUSY) busy_fall_cyc <= cyc;
      busy_q <= BUSY;
      if (GOT_FULL_MSG != 0 && gfm_cyc < 0) gfm_cyc <= cyc;
      if (OUT_VALID && OUT_SOP && hdr_cyc < 0) hdr_cyc <= cyc;
      if (MSG_START != 0 && RD_REQ != 0) excl_err <= excl_err + 1;
      if (RD_REQ != 0 && RD_REQ != (2'b01 << CUR_CH))
        excl_err <= excl_err + 1;
      if (MSG_START != 0 && MSG_START != (2'b01 << CUR_CH))
        excl_err <= excl_err + 1;
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge SYS_CLK); #1;
    RST = 1'b1;
    @(posedge SYS_CLK); #1;
    RST = 1'b0;
  endtask

  task automatic arm(input logic [15:0] lens);
    @(posedge SYS_CLK); #1;
    mon_clr = 1'b1;
    MSG_LEN = lens;
    @(posedge SYS_CLK); #1;
    mon_clr = 1'b0;
  endtask

  task automatic go(input logic [1:0] req, input logic [15:0] lens,
                    input logic [3:0] pat, input int budget);
    int n;
    bit seen;
    bit fin;
    n = 0; seen = 0; fin = 0;
    arm(lens);
    GOT_FULL_MSG = req;
    OUT_READY = pat[0];
    while (!fin && n < budget) begin
      @(posedge SYS_CLK); #1;
      n++;
      GOT_FULL_MSG = GOT_FULL_MSG & ~MSG_START;
      OUT_READY = pat[n % 4];
      if (BUSY) seen = 1;
      else if (seen && GOT_FULL_MSG == 0) fin = 1;
    end
    chk("timeout", 32'(fin), 1);
    repeat (2) @(posedge SYS_CLK);
    #1;
  endtask

  initial begin
    int n;
    int seq_bad;
    RST = 1'b1;
    GOT_FULL_MSG = '0;
    MSG_LEN = '0;
    OUT_READY = 1'b0;
    #12;
    chk("rst_valid", 32'(OUT_VALID), 0);
    chk("rst_busy",  32'(BUSY), 0);
    chk("rst_start", 32'(MSG_START), 0);
    chk("rst_rdreq", 32'(RD_REQ), 0);
    chk("rst_data",  32'({OUT_SOP, OUT_EOP, OUT_DATA}), 0);
    chk("rst_cur",   32'(CUR_CH), 0);
    @(posedge SYS_CLK); #1;
    RST = 1'b0;

    // Single message on ch0, len 3
    go(2'b01, {8'd0, 8'd3}, 4'hF, 40);
    chk("t1_size", got_q.size(), 4);
    chk("t1_w0", 32'(got_q[0]), {14'd0, 2'b10, 16'hA003});
    chk("t1_w1", 32'(got_q[1]), {14'd0, 2'b00, 16'h0100});
    chk("t1_w2", 32'(got_q[2]), {14'd0, 2'b00, 16'h0101});
    chk("t1_w3", 32'(got_q[3]), {14'd0, 2'b01, 16'h0102});
    chk("t1_mstart", ms_cnt[0], 1);
    chk("t1_rdreq", rd_cnt[0], 3);
    chk("t1_rdreq1", rd_cnt[1], 0);
    chk("t1_vrun", max_run, 4);
    chk("t1_lat", hdr_cyc - gfm_cyc, 4);
    chk("t1_excl", excl_err, 0);

    // Both channels after reset, len 2 each
    do_reset();
    go(2'b11, {8'd2, 8'd2}, 4'hF, 60);
    chk("t2_size", got_q.size(), 6);
    chk("t2_w0", 32'(got_q[0]), {14'd0, 2'b10, 16'hA002});
    chk("t2_w2", 32'(got_q[2]), {14'd0, 2'b01, 16'h0101});
    chk("t2_w3", 32'(got_q[3]), {14'd0, 2'b10, 16'hA102});
    chk("t2_w5", 32'(got_q[5]), {14'd0, 2'b01, 16'h0201});
    chk("t2_excl", excl_err, 0);
    go(2'b11, {8'd2, 8'd2}, 4'hF, 60);
    chk("t2_rr_first", 32'(got_q[0]), {14'd0, 2'b10, 16'hA002});
    chk("t2_rr_second", 32'(got_q[3]), {14'd0, 2'b10, 16'hA102});

    // Zero length on ch1
    go(2'b10, {8'd0, 8'd0}, 4'hF, 40);
    chk("t3_size", got_q.size(), 1);
    chk("t3_w0", 32'(got_q[0]), {14'd0, 2'b11, 16'hA100});
    chk("t3_rdreq", rd_cnt[1] + rd_cnt[0], 0);

    // Backpressure, ready 1,0,0,1 repeating
    go(2'b01, {8'd0, 8'd5}, 4'b1001, 80);
    chk("t4_size", got_q.size(), 6);
    chk("t4_w0", 32'(got_q[0]), {14'd0, 2'b10, 16'hA005});
    chk("t4_w1", 32'(got_q[1]), {14'd0, 2'b00, 16'h0100});
    chk("t4_w3", 32'(got_q[3]), {14'd0, 2'b00, 16'h0102});
    chk("t4_w5", 32'(got_q[5]), {14'd0, 2'b01, 16'h0104});
    chk("t4_rdreq", rd_cnt[0], 5);
    chk("t4_stall_err", stall_err, 0);
    chk("t4_stall_seen", 32'(stall_n > 0), 1);
    chk("t4_max_out", 32'(max_out <= 2), 1);

    // Maximum contract length
    go(2'b01, {8'd0, 8'd254}, 4'hF, 400);
    chk("t5_size", got_q.size(), 255);
    chk("t5_hdr", 32'(got_q[0]), {14'd0, 2'b10, 16'hA0FE});
    chk("t5_last", 32'(got_q[254]), {14'd0, 2'b01, 16'h01FD});
    seq_bad = 0;
    for (int k = 1; k < 255; k++)
      if (got_q[k] !== {1'b0, k == 254, 16'(16'h0100 + k - 1)})
        seq_bad++;
    chk("t5_seq", seq_bad, 0);
    chk("t5_rdreq", rd_cnt[0], 254);
    chk("t5_vrun", max_run, 255);
    chk("t5_busy_fall", busy_fall_cyc - last_pop_cyc, 1);

    // Reset in the middle of a ch1 payload
    arm({8'd20, 8'd20});
    GOT_FULL_MSG = 2'b10;
    OUT_READY = 1'b1;
    n = 0;
    while (rd_cnt[1] < 10 && n < 100) begin
      @(posedge SYS_CLK); #1;
      GOT_FULL_MSG = GOT_FULL_MSG & ~MSG_START;
      n++;
    end
    chk("t6_reach", 32'(rd_cnt[1] >= 10), 1);
    chk("t6_busy_pre", 32'(BUSY), 1);
    chk("t6_cur_pre", 32'(CUR_CH), 1);
    #3;
    RST = 1'b1;
    GOT_FULL_MSG = '0;
    #1;
    chk("t6_valid", 32'(OUT_VALID), 0);
    chk("t6_busy", 32'(BUSY), 0);
    chk("t6_rdreq", 32'(RD_REQ), 0);
    chk("t6_cur", 32'(CUR_CH), 0);
    chk("t6_eop", 32'(OUT_EOP), 0);
    chk("t6_data", 32'(OUT_DATA), 0);
    @(posedge SYS_CLK); #1;
    RST = 1'b0;
    go(2'b11, {8'd1, 8'd1}, 4'hF, 60);
    chk("t6_size", got_q.size(), 4);
    chk("t6_w0", 32'(got_q[0]), {14'd0, 2'b10, 16'hA001});
    chk("t6_w1", 32'(got_q[1]), {14'd0, 2'b01, 16'h0100});
    chk("t6_w2", 32'(got_q[2]), {14'd0, 2'b10, 16'hA101});
    chk("t6_w3", 32'(got_q[3]), {14'd0, 2'b01, 16'h0200});

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
